// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus for the ID/EX pipeline register: decode-side fields,
// execute-side registered copies, flush request and hazard stall outputs.
interface id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
);
    // Decode side
    logic             ValidD;
    logic             MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, RegWriteD, JumpD;
    logic [1:0]       ALUOpD;
    logic [2:0]       ALUControlD;
    logic [WIDTH-1:0] RD1D, RD2D;
    logic [RADDR-1:0] RsD, RtD, RdD;
    logic [WIDTH-1:0] SignImmD, PCPlus4D;
    logic             FlushE;

    // Execute side
    logic             ValidE;
    logic             MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, RegWriteE, JumpE;
    logic [1:0]       ALUOpE;
    logic [2:0]       ALUControlE;
    logic [WIDTH-1:0] RD1E, RD2E;
    logic [RADDR-1:0] RsE, RtE, RdE;
    logic [WIDTH-1:0] SignImmE, PCPlus4E;

    logic             StallF, StallD;

    modport master (
        output ValidD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, RegWriteD, JumpD,
               ALUOpD, ALUControlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD, PCPlus4D, FlushE,
        input  ValidE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, RegWriteE, JumpE,
               ALUOpE, ALUControlE, RD1E, RD2E, RsE, RtE, RdE, SignImmE, PCPlus4E,
               StallF, StallD
    );

    modport slave (
        input  ValidD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, RegWriteD, JumpD,
               ALUOpD, ALUControlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD, PCPlus4D, FlushE,
        output ValidE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, RegWriteE, JumpE,
               ALUOpE, ALUControlE, RD1E, RD2E, RsE, RtE, RdE, SignImmE, PCPlus4E,
               StallF, StallD
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional macro ID_EX_BUBBLE_COUNT_EN adds a saturating 16-bit BubbleCount output.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input logic CLK,
    input logic RST,
    id_ex_stage_if.slave bus
`ifdef ID_EX_BUBBLE_COUNT_EN
    ,
    output logic [15:0] BubbleCount
`endif
);

    typedef struct packed {
        logic             valid;
        logic             memtoreg;
        logic             memwrite;
        logic             branch;
        logic             alusrc;
        logic             regdst;
        logic             regwrite;
        logic             jump;
        logic [1:0]       aluop;
        logic [2:0]       alucontrol;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic [RADDR-1:0] rd;
        logic [WIDTH-1:0] signimm;
        logic [WIDTH-1:0] pcplus4;
    } stage_t;

    stage_t d_in;
    stage_t e_q;
    logic   lwstall;
    logic   bubble;

    assign d_in = '{valid: bus.ValidD, memtoreg: bus.MemtoRegD, memwrite: bus.MemWriteD,
                    branch: bus.BranchD, alusrc: bus.ALUSrcD, regdst: bus.RegDstD,
                    regwrite: bus.RegWriteD, jump: bus.JumpD, aluop: bus.ALUOpD,
                    alucontrol: bus.ALUControlD, rd1: bus.RD1D, rd2: bus.RD2D,
                    rs: bus.RsD, rt: bus.RtD, rd: bus.RdD,
                    signimm: bus.SignImmD, pcplus4: bus.PCPlus4D};

    // A load in E whose destination is read by a valid D instruction must wait one
    // cycle; $0 is never a real destination. Stall is asserted for the whole cycle
    // and upstream holds PC and IF/ID; the inserted bubble clears the condition.
    assign lwstall = e_q.valid & e_q.memtoreg & e_q.regwrite & (e_q.rt != '0) &
                     bus.ValidD & ((e_q.rt == bus.RsD) | (e_q.rt == bus.RtD));
    assign bubble  = bus.FlushE | lwstall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            e_q <= '0;
        end else if (bubble) begin
            e_q <= '0;
        end else begin
            e_q <= d_in;
        end
    end

    assign bus.StallF      = lwstall;
    assign bus.StallD      = lwstall;
    assign bus.ValidE      = e_q.valid;
    assign bus.MemtoRegE   = e_q.memtoreg;
    assign bus.MemWriteE   = e_q.memwrite;
    assign bus.BranchE     = e_q.branch;
    assign bus.ALUSrcE     = e_q.alusrc;
    assign bus.RegDstE     = e_q.regdst;
    assign bus.RegWriteE   = e_q.regwrite;
    assign bus.JumpE       = e_q.jump;
    assign bus.ALUOpE      = e_q.aluop;
    assign bus.ALUControlE = e_q.alucontrol;
    assign bus.RD1E        = e_q.rd1;
    assign bus.RD2E        = e_q.rd2;
    assign bus.RsE         = e_q.rs;
    assign bus.RtE         = e_q.rt;
    assign bus.RdE         = e_q.rd;
    assign bus.SignImmE    = e_q.signimm;
    assign bus.PCPlus4E    = e_q.pcplus4;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [15:0] bubble_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            bubble_cnt_q <= '0;
        end else if (bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage MIPS core, sitting directly downstream of the main decoder and ALU decoder. Captures the decode-stage control word, register-file read data, register specifiers, sign-extended immediate and PC+4 each cycle, and presents them to the execute stage. Contains the load-use hazard detector: it stalls fetch and decode and inserts a bubble into execute when needed. Also inserts a bubble on a flush request from branch or jump resolution.

## Interface
- Parameters:
  - `WIDTH`, 32, datapath width.
  - `RADDR`, 5, register specifier width.
- Reset and clock: one clock `CLK`; reset `RST` is synchronous and active-high.
- Ports:
  - `CLK` in 1: clock; all state updates on rising edge.
  - `RST` in 1: synchronous active-high reset.
  - `ValidD` in 1: decode slot holds a real instruction.
  - `MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, RegWriteD, JumpD` in 1 each: decoder control bits.
  - `ALUOpD` in 2: decoder ALU op class.
  - `ALUControlD` in 3: ALU decoder output.
  - `RD1D, RD2D` in WIDTH: register-file read data.
  - `RsD, RtD, RdD` in RADDR: instruction register fields.
  - `SignImmD, PCPlus4D` in WIDTH: sign-extended immediate; PC+4.
  - `FlushE` in 1: branch/jump taken; kill the instruction entering E.
  - `*E` outputs, same widths as the matching `*D` inputs: registered copies of every field above, plus `ValidE`.
  - `StallF, StallD` out 1: hold PC and the IF/ID register this cycle.
  - `BubbleCount` out 16: present only with `ID_EX_BUBBLE_COUNT_EN`.

## Operation
- Load-use hazard (combinational): `lwstall = ValidE & MemtoRegE & RegWriteE & (RtE != 0) & ValidD & ((RtE == RsD) | (RtE == RtD))`.
- `StallF = StallD = lwstall`.
- `bubble = FlushE | lwstall`.
- Each rising edge, in priority order:
  - `RST`: every E output is 0, `ValidE` is 0, and `BubbleCount` is 0.
  - `bubble`: every E output is 0 (control and data), and `ValidE` is 0.
  - Otherwise: every E output takes its D input, and `ValidE` takes `ValidD`.
- A bubble is architecturally a NOP: all write and memory enables are 0 and `Branch`/`Jump` are 0.
- `FlushE` together with `lwstall`: a single bubble. Stall outputs still assert that cycle; the upstream flush logic overrides the IF/ID hold.
- `ValidD = 0` with no bubble: fields are captured as-is, `ValidE` is 0, and the hazard detector ignores the slot.
- Register `$0` is never a hazard source (the `RtE != 0` term).
- No arithmetic on data fields; pure transport.

## Timing
- Latency: 1 cycle from D inputs to E outputs.
- `StallF`/`StallD` are combinational from the current E registers and D inputs, valid in the same cycle.
- Load-use sequence:
  - Cycle N: lw in E, dependent instruction in D. `lwstall = 1`; the IF/ID register and PC hold.
  - Edge N+1: E loads a bubble. The dependent instruction is still in D.
  - Cycle N+1: `MemtoRegE = 0`, so `lwstall = 0`.
  - Edge N+2: the dependent instruction enters E.
- Stall is exactly one cycle per load-use pair.
- Back-to-back lw, each dependent on the previous: one stall per pair, with no extra stalls.
- `RST` asserted mid-stall: the next edge clears everything, and the stall deasserts on the following cycle.
- D inputs must remain stable while `StallD = 1`; the decoder is combinational from the held IF/ID register.

## Configuration
- `ID_EX_BUBBLE_COUNT_EN` defined:
  - Adds output `BubbleCount[15:0]`.
  - Increments by 1 on each edge where `bubble = 1` and `RST = 0`.
  - Saturates at 16'hFFFF.
  - Cleared by `RST`.
- `ID_EX_BUBBLE_COUNT_EN` not defined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold `RST=1` for 2 cycles with arbitrary nonzero D inputs -> every E output is 0, `ValidE=0`, and `BubbleCount=0`.
- Pass-through: `ValidD=1`, R-type word (`RegWriteD=1`, `RegDstD=1`, `ALUOpD=2'b10`, `ALUControlD=3'b010`, `RD1D=32'h1234`, `RdD=5'd8`) -> the same values appear on E outputs one edge later, with `ValidE=1`.
- Load-use:
  - Stimulus: lw (`MemtoRegD=1`, `RegWriteD=1`, `RtD=5'd9`), then add with `RsD=5'd9`.
  - Required response:
    - `StallD=StallF=1` for exactly one cycle.
    - The next E contents are all zero.
    - The add reaches E on the following edge.
    - `BubbleCount=1`.
- `$0` exemption: lw with `RtD=0`, followed by an instruction using `RsD=0` -> no stall.
- Flush: `FlushE=1` for one cycle while a sw (`MemWriteD=1`) is in D -> `MemWriteE=0` and `ValidE=0` next cycle; no stall asserted.
- Counter saturation (macro on): force 70000 consecutive flush cycles -> `BubbleCount` holds at 16'hFFFF.
